// File: rtl/pipeline_pkg.sv
// Shared decode definitions for the RV32 pipeline: opcodes, immediate formats, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Base RV32 major opcodes (bits [6:0], including the 2'b11 length bits)
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/pipeline_regfile.sv
// Architectural register file, 2 read ports / 1 write port, x0 hardwired to zero.
// Latency: reads combinational, write visible after the clock edge.
// Backpressure: none; writes outside 1..NUM_REGS-1 are silently dropped.
//
// Ports: clk_i, rst_ni (sync, active-low, clears all entries),
//        raddr1/rdata1, raddr2/rdata2 (read; out-of-range or x0 return 0),
//        we/waddr/wdata (write-back).
// NUM_REGS must be a power of two (16 for RV32E, 32 for RV32I).
module pipeline_regfile
  import pipeline_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];

  // x0 and indices beyond the implemented range are never stored or returned
  function automatic logic idx_live(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < NUM_REGS);
  endfunction

  assign rdata1 = idx_live(raddr1) ? regs[raddr1[REG_AW-1:0]] : '0;
  assign rdata2 = idx_live(raddr2) ? regs[raddr2[REG_AW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && idx_live(waddr)) begin
      regs[waddr[REG_AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pipeline_id_stage.sv
// RV32I/RV32E instruction decode stage: field split, immediate generation, operand read.
// Latency: 1 cycle instruction_i -> registered ID/EX slot; 1 instruction per cycle.
// Backpressure: id_ready_o = !id_valid_o || ex_ready_i; slot holds while execute stalls.
//
// Ports: clk_i, rst_ni (sync, active-low); fetch side if_valid_i/instruction_i/pc_i/id_ready_o;
//        execute side ex_ready_i and the registered slot outputs (id_valid_o, pc_o, fields,
//        read_data1_o/read_data2_o, imm_o, illegal_o); flush_i; write-back
//        reg_write_i/write_addr_reg_i/write_data_reg_i.
// Build option PIPELINE_ID_WB_BYPASS_EN: forward same-cycle write-back into captured operands
// and refresh operands of a held slot.
module pipeline_id_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  input  logic [31:0]     instruction_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            id_ready_o,
  input  logic            ex_ready_i,
  input  logic            flush_i,
  input  logic            reg_write_i,
  input  logic [4:0]      write_addr_reg_i,
  input  logic [XLEN-1:0] write_data_reg_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] read_data1_o,
  output logic [XLEN-1:0] read_data2_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic [6:0]      opc_dec;
  logic [4:0]      rd_dec, rs1_dec, rs2_dec;
  logic [2:0]      f3_dec;
  logic [6:0]      f7_dec;
  imm_fmt_e        fmt;
  logic            opc_known, rd_used, rs1_used, rs2_used;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            illegal_dec;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] op1_dec, op2_dec;
  logic            accept;

  assign opc_dec = instruction_i[6:0];
  assign rd_dec  = instruction_i[11:7];
  assign f3_dec  = instruction_i[14:12];
  assign rs1_dec = instruction_i[19:15];
  assign rs2_dec = instruction_i[24:20];
  assign f7_dec  = instruction_i[31:25];

  // Opcode class: immediate format and which register fields are architecturally read/written
  always_comb begin
    fmt       = IMM_NONE;
    opc_known = 1'b1;
    rd_used   = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    case (opc_dec)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        fmt      = IMM_I;
        rd_used  = 1'b1;
        rs1_used = 1'b1;
      end
      OPC_STORE: begin
        fmt      = IMM_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        fmt      = IMM_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt     = IMM_U;
        rd_used = 1'b1;
      end
      OPC_JAL: begin
        fmt     = IMM_J;
        rd_used = 1'b1;
      end
      OPC_OP: begin
        rd_used  = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_MISC_MEM: begin
        fmt = IMM_NONE;
      end
      default: begin
        opc_known = 1'b0;
      end
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instruction_i[31]}}, instruction_i[31:20]};
      IMM_S:   imm32 = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      IMM_B:   imm32 = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                        instruction_i[30:25], instruction_i[11:8], 1'b0};
      IMM_U:   imm32 = {instruction_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                        instruction_i[20], instruction_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Bit 31 is the sign of every format, so a signed widening covers XLEN > 32
  assign imm_ext = XLEN'($signed(imm32));

  // RV32E: any referenced register index past the implemented file is illegal
  assign illegal_dec = (instruction_i[1:0] != 2'b11) || !opc_known
                    || (rd_used  && (int'(rd_dec)  >= NUM_REGS))
                    || (rs1_used && (int'(rs1_dec) >= NUM_REGS))
                    || (rs2_used && (int'(rs2_dec) >= NUM_REGS));

  pipeline_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raddr1 (rs1_dec),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2_dec),
    .rdata2 (rf_rdata2),
    .we     (reg_write_i),
    .waddr  (write_addr_reg_i),
    .wdata  (write_data_reg_i)
  );

`ifdef PIPELINE_ID_WB_BYPASS_EN
  // Same write-enable qualification the register file applies, so x0 and
  // out-of-range indices never forward
  logic wb_en;
  assign wb_en   = reg_write_i && (write_addr_reg_i != 5'd0) && (int'(write_addr_reg_i) < NUM_REGS);
  assign op1_dec = (wb_en && (write_addr_reg_i == rs1_dec)) ? write_data_reg_i : rf_rdata1;
  assign op2_dec = (wb_en && (write_addr_reg_i == rs2_dec)) ? write_data_reg_i : rf_rdata2;
`else
  assign op1_dec = rf_rdata1;
  assign op2_dec = rf_rdata2;
`endif

  assign id_ready_o = !id_valid_o || ex_ready_i;
  assign accept     = if_valid_i && id_ready_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_valid_o   <= 1'b0;
      pc_o         <= '0;
      opcode_o     <= '0;
      funct3_o     <= '0;
      funct7_o     <= '0;
      rs1_o        <= '0;
      rs2_o        <= '0;
      rd_o         <= '0;
      read_data1_o <= '0;
      read_data2_o <= '0;
      imm_o        <= '0;
      illegal_o    <= 1'b0;
    end else if (flush_i) begin
      // Only the valid bit is killed; the rest of the slot is don't-care
      id_valid_o <= 1'b0;
    end else if (accept) begin
      id_valid_o   <= 1'b1;
      pc_o         <= pc_i;
      opcode_o     <= opc_dec;
      funct3_o     <= f3_dec;
      funct7_o     <= f7_dec;
      rs1_o        <= rs1_dec;
      rs2_o        <= rs2_dec;
      rd_o         <= rd_dec;
      read_data1_o <= op1_dec;
      read_data2_o <= op2_dec;
      imm_o        <= imm_ext;
      illegal_o    <= illegal_dec;
    end else if (ex_ready_i) begin
      id_valid_o <= 1'b0;
    end
`ifdef PIPELINE_ID_WB_BYPASS_EN
    // Slot stalled: keep held operands coherent with write-back
    else if (id_valid_o && wb_en) begin
      if (write_addr_reg_i == rs1_o) read_data1_o <= write_data_reg_i;
      if (write_addr_reg_i == rs2_o) read_data2_o <= write_data_reg_i;
    end
`endif
  end

endmodule
